// File: rtl/seg_display_mux_if.sv
// Display-side bundle for seg_display_mux: hex/dp data and controls in, segment/anode drive out.
interface seg_display_mux_if #(
    parameter int NUM_DIGITS   = 8,
    parameter int BRIGHT_WIDTH = 4
);
    logic [4*NUM_DIGITS-1:0] data_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    live_in;
    logic                    load_in;
    logic                    blank_lz_in;
    logic [BRIGHT_WIDTH-1:0] brightness_in;
    logic [6:0]              seg_out;
    logic                    dp_out;
    logic [NUM_DIGITS-1:0]   strobe_out;

    modport master (
        output data_in, dp_in, live_in, load_in, blank_lz_in, brightness_in,
        input  seg_out, dp_out, strobe_out
    );

    modport slave (
        input  data_in, dp_in, live_in, load_in, blank_lz_in, brightness_in,
        output seg_out, dp_out, strobe_out
    );
endinterface

// File: rtl/seg_display_mux.sv
// N-digit common-anode seven-segment scanner: frame-coherent shadow, leading-zero blanking, PWM dimming.
// Outputs registered one cycle after counter state; free-running, no backpressure.
module seg_display_mux #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16,
    parameter int BRIGHT_WIDTH = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rstn,
    seg_display_mux_if.slave bus
);
    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
    localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

    logic [DIV_W-1:0]        div_cnt;
    logic [IDX_W-1:0]        idx;
    logic [BRIGHT_WIDTH-1:0] pwm_cnt;
    logic [4*NUM_DIGITS-1:0] shadow_dat;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic                    load_pending;

    logic                    slot_end;
    logic                    frame_end;
    logic                    capture;
    logic                    pwm_on;
    logic                    anode_on;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    zero_run;
    logic [3:0]              nib_sel;
    logic                    dp_sel;
    logic                    blank_sel;
    logic [6:0]              seg_nxt;
    logic [NUM_DIGITS-1:0]   strobe_nxt;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    assign slot_end  = (div_cnt == DIV_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);
    // A load arriving in the boundary cycle itself is honoured immediately.
    assign capture   = frame_end && (bus.live_in || load_pending || bus.load_in);
    assign pwm_on    = (bus.brightness_in == '1) || (pwm_cnt < bus.brightness_in);
    assign anode_on  = (div_cnt >= BLANK_END) && pwm_on;

    // lz_mask[i] set when shadow nibbles i..top are all zero.
    always_comb begin
        lz_mask  = '0;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run   = zero_run & (shadow_dat[4*i +: 4] == 4'h0);
            lz_mask[i] = zero_run;
        end
    end

    always_comb begin
        nib_sel    = 4'h0;
        dp_sel     = 1'b0;
        blank_sel  = 1'b0;
        strobe_nxt = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                nib_sel       = shadow_dat[4*i +: 4];
                dp_sel        = shadow_dp[i];
                blank_sel     = bus.blank_lz_in && (i != 0) && lz_mask[i];
                strobe_nxt[i] = ~anode_on;
            end
        end
        seg_nxt = blank_sel ? 7'h7F : hex_to_seg(nib_sel);
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            div_cnt        <= '0;
            idx            <= '0;
            pwm_cnt        <= '0;
            shadow_dat     <= '0;
            shadow_dp      <= '0;
            load_pending   <= 1'b0;
            bus.seg_out    <= 7'h7F;
            bus.dp_out     <= 1'b1;
            bus.strobe_out <= '1;
        end else begin
            pwm_cnt <= pwm_cnt + BRIGHT_WIDTH'(1);
            if (slot_end) begin
                div_cnt <= '0;
                idx     <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end

            if (capture) begin
                shadow_dat   <= bus.data_in;
                shadow_dp    <= bus.dp_in;
                load_pending <= 1'b0;
            end else if (bus.load_in) begin
                load_pending <= 1'b1;
            end

            // Glyph changes with the index, while the anodes are still in the blank window.
            bus.seg_out    <= seg_nxt;
            bus.dp_out     <= ~dp_sel;
            bus.strobe_out <= strobe_nxt;
        end
    end
endmodule

// File: tb/tb_seg_display_mux.sv
// Bench for seg_display_mux (4 digits, 8-cycle slots, 2-cycle blank, 2-bit brightness).
module tb_seg_display_mux;
    localparam int ND = 4;
    localparam int RD = 8;
    localparam int BL = 2;
    localparam int BW = 2;

    logic sys_clk = 1'b0;
    logic sys_rstn;

    seg_display_mux_if #(.NUM_DIGITS(ND), .BRIGHT_WIDTH(BW)) bus ();

    seg_display_mux #(
        .NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BL), .BRIGHT_WIDTH(BW)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rstn(sys_rstn),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] hexseg(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return t[n];
    endfunction

    // Scoreboard: model time-indexed from reset, pushes expected {strobe,dp,seg} per edge.
    logic [11:0]   sb_q[$];
    int            mc;
    logic [15:0]   m_dat;
    logic [3:0]    m_dp;
    bit            m_pend;
    int            m_div, m_ix, m_pw;
    bit            m_on, m_blk;
    logic [3:0]    m_st;
    logic [3:0]    m_nib;

    always @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            mc = 0; m_dat = '0; m_dp = '0; m_pend = 0;
            sb_q.delete();
        end else begin
            m_div = mc % RD;
            m_ix  = (mc / RD) % ND;
            m_pw  = mc % (1 << BW);
            m_on  = (bus.brightness_in == 2'd3) || (m_pw < int'(bus.brightness_in));
            m_st  = (m_div >= BL && m_on) ? ~(4'b0001 << m_ix) : 4'hF;
            m_nib = m_dat[4*m_ix +: 4];
            m_blk = bus.blank_lz_in && (m_ix > 0) && ((m_dat >> (4*m_ix)) == 16'h0);
            sb_q.push_back({m_st, ~m_dp[m_ix], m_blk ? 7'h7F : hexseg(m_nib)});
            if (m_div == RD - 1 && m_ix == ND - 1) begin
                if (bus.live_in || m_pend || bus.load_in) begin
                    m_dat = bus.data_in; m_dp = bus.dp_in; m_pend = 0;
                end
            end else if (bus.load_in) begin
                m_pend = 1;
            end
            mc++;
        end
    end

    logic [11:0] sb_e;
    always @(posedge sys_clk) begin
        #1;
        if (sys_rstn && sb_q.size() > 0) begin
            sb_e = sb_q.pop_front();
            chk("scan", {bus.strobe_out, bus.dp_out, bus.seg_out}, sb_e);
        end
    end

    task automatic probe(input string tag, input int d, input logic [6:0] s, input logic dpv);
        bit found = 0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(posedge sys_clk); #2;
            if (bus.strobe_out == ~(4'b0001 << d)) found = 1;
        end
        chk({tag, "_found"}, found, 1);
        if (found) begin
            chk({tag, "_seg"}, bus.seg_out, s);
            chk({tag, "_dp"}, bus.dp_out, dpv);
        end
    endtask

    task automatic wait_phase(input int ph);
        bit found = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge sys_clk);
            if (mc % (ND*RD) == ph) found = 1;
        end
        chk("phase_found", found, 1);
    endtask

    task automatic count_lows(input string tag, input int exp);
        int lows = 0;
        for (int k = 0; k < ND*RD; k++) begin
            @(posedge sys_clk); #2;
            if (bus.strobe_out != 4'hF) lows++;
        end
        chk(tag, lows, exp);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rstn = 1'b0;
        bus.data_in = '0; bus.dp_in = '0; bus.live_in = 0; bus.load_in = 0;
        bus.blank_lz_in = 0; bus.brightness_in = 2'd3;
        repeat (3) @(negedge sys_clk);
        chk("rst_seg", bus.seg_out, 7'h7F);
        chk("rst_dp", bus.dp_out, 1'b1);
        chk("rst_strobe", bus.strobe_out, 4'hF);
        sys_rstn = 1'b1;

        // Slot 0 anode low on edges 3..8, same again one frame later.
        for (int n = 1; n <= 35; n++) begin
            @(posedge sys_clk); #2;
            if (n <= 9) chk("rel_strobe", bus.strobe_out, (n >= 3 && n <= 8) ? 4'hE : 4'hF);
            if (n == 34) chk("period_blank", bus.strobe_out, 4'hF);
            if (n == 35) chk("period_on", bus.strobe_out, 4'hE);
        end

        @(negedge sys_clk);
        bus.live_in = 1; bus.data_in = 16'h12AF; bus.dp_in = 4'b0100;
        repeat (64) @(negedge sys_clk);
        probe("live_d0", 0, 7'b0001110, 1'b1);
        probe("live_d1", 1, 7'b0001000, 1'b1);
        probe("live_d2", 2, 7'b0100100, 1'b0);
        probe("live_d3", 3, 7'b1111001, 1'b1);

        @(negedge sys_clk);
        bus.data_in = 16'h1234; bus.dp_in = 4'b0000;
        repeat (64) @(negedge sys_clk);
        bus.live_in = 0; bus.data_in = 16'h5678;
        repeat (96) @(negedge sys_clk);
        probe("latch_d3", 3, 7'b1111001, 1'b1);
        probe("latch_d0", 0, 7'b0011001, 1'b1);
        wait_phase(12);
        bus.load_in = 1;
        @(negedge sys_clk);
        bus.load_in = 0;
        repeat (64) @(negedge sys_clk);
        probe("load_d3", 3, 7'b0010010, 1'b1);
        probe("load_d0", 0, 7'b0000000, 1'b1);

        // Load coincident with the boundary: captured now, nothing left pending.
        wait_phase(ND*RD - 1);
        bus.data_in = 16'h9ABC; bus.load_in = 1;
        @(negedge sys_clk);
        bus.load_in = 0; bus.data_in = 16'hDEF0;
        repeat (96) @(negedge sys_clk);
        probe("bnd_d3", 3, 7'b0010000, 1'b1);
        probe("bnd_d0", 0, 7'b1000110, 1'b1);

        bus.live_in = 1; bus.blank_lz_in = 1; bus.data_in = 16'h0005;
        repeat (64) @(negedge sys_clk);
        probe("lz5_d3", 3, 7'h7F, 1'b1);
        probe("lz5_d0", 0, 7'b0010010, 1'b1);
        bus.data_in = 16'h0000;
        repeat (64) @(negedge sys_clk);
        probe("lz0_d0", 0, 7'b1000000, 1'b1);
        probe("lz0_d1", 1, 7'h7F, 1'b1);
        bus.data_in = 16'h0100;
        repeat (64) @(negedge sys_clk);
        probe("lz100_d3", 3, 7'h7F, 1'b1);
        probe("lz100_d1", 1, 7'b1000000, 1'b1);
        probe("lz100_d2", 2, 7'b1111001, 1'b1);

        @(negedge sys_clk);
        bus.blank_lz_in = 0; bus.brightness_in = 2'd1;
        count_lows("bright1", 4);
        @(negedge sys_clk);
        bus.brightness_in = 2'd0;
        count_lows("bright0", 0);
        @(negedge sys_clk);
        bus.brightness_in = 2'd3;
        count_lows("bright3", 24);

        // Asynchronous reset during digit 2, between clock edges.
        @(negedge sys_clk);
        bus.live_in = 0; bus.blank_lz_in = 1;
        probe("pre_rst_d2", 2, 7'b1111001, 1'b1);
        #1 sys_rstn = 1'b0;
        #1;
        chk("arst_seg", bus.seg_out, 7'h7F);
        chk("arst_dp", bus.dp_out, 1'b1);
        chk("arst_strobe", bus.strobe_out, 4'hF);
        repeat (2) @(negedge sys_clk);
        sys_rstn = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            @(posedge sys_clk); #2;
        end
        chk("rerst_strobe", bus.strobe_out, 4'hE);
        chk("rerst_seg", bus.seg_out, 7'b1000000);
        probe("rerst_d1", 1, 7'h7F, 1'b1);

        repeat (4) @(negedge sys_clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
